// File: rtl/system_set_pkg.sv
// rtl/system_set_pkg.sv - shared types, register offsets and bit positions for the SET scanner
package system_set_pkg;

    typedef enum logic [2:0] {
        ST_WR_MASK = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_CAP  = 3'd4,
        ST_PUSH    = 3'd5
    } state_e;

    // PIO register offsets
    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_MASK = 2'd2;

    // CPU slave register offsets
    localparam logic [1:0] REG_EVENT  = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_MASK   = 2'd2;
    localparam logic [1:0] REG_SETTLE = 2'd3;

    // EVENT word fields
    localparam int EVT_DIFF_LSB  = 8;
    localparam int EVT_VALID_BIT = 15;
    localparam int EVT_TS_LSB    = 16;

    // STATUS word fields
    localparam int STAT_OVF_BIT  = 8;
    localparam int STAT_BUSY_BIT = 9;

endpackage

// File: rtl/system_set_event_fifo.sv
// rtl/system_set_event_fifo.sv - single-clock event FIFO, pop wins a slot when full
module system_set_event_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/system_set_scanner.sv
// rtl/system_set_scanner.sv - SET button PIO scanner with event FIFO; option SYSTEM_SET_SCANNER_TIMESTAMP_EN
module system_set_scanner
    import system_set_pkg::*;
#(
    parameter int              WIDTH        = 5,
    parameter int              FIFO_DEPTH   = 8,
    parameter logic [WIDTH-1:0] MASK_RESET  = WIDTH'(5'h1F),
    parameter logic [15:0]     SETTLE_RESET = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        pio_irq,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef SYSTEM_SET_SCANNER_TIMESTAMP_EN
    localparam int FW = 32;
`else
    localparam int FW = 16;
`endif

    state_e            state_q, state_d;
    logic              go_q, go_d;
    logic [WIDTH-1:0]  mask_q, mask_d, last_q, last_d, sample_q, sample_d, diff;
    logic [15:0]       settle_q, settle_d, timer_q, timer_d;
    logic              mask_dirty_q, mask_dirty_d, overflow_q, overflow_d, irq_q, irq_d;
    logic [31:0]       readdata_q, readdata_d, status_word;
    logic              cpu_rd, cpu_wr, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]     evt_word, fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic              unused_bits;
`ifdef SYSTEM_SET_SCANNER_TIMESTAMP_EN
    logic [15:0]       ts_q, ts_d, ts_cap_q, ts_cap_d;
`endif

    assign cpu_rd      = chipselect & ~read_n;
    assign cpu_wr      = chipselect & ~write_n;
    assign fifo_pop    = cpu_rd & (address == REG_EVENT);
    assign diff        = (sample_q ^ last_q) & mask_q;
    assign fifo_push   = (state_q == ST_PUSH) & (|diff);
    assign readdata    = readdata_q;
    assign irq         = irq_q;
    assign unused_bits = ^{writedata[31:16], avm_readdata[31:WIDTH]};

    system_set_event_fifo #(.DW(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (fifo_push),
        .push_data (evt_word),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WR_MASK;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // FSM next state; go_q holds the first mask write until the clock after reset release
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_WR_MASK: if (go_q) state_d = ST_IDLE;
            ST_IDLE: begin
                if (mask_dirty_q) begin
                    state_d = ST_WR_MASK;
                end else if (pio_irq || |(last_q & mask_q)) begin
                    state_d = ST_SETTLE;
                    timer_d = (settle_q == 16'd0) ? 16'd1 : settle_q;
                end
            end
            ST_SETTLE: begin
                if (timer_q <= 16'd1) state_d = ST_RD_REQ;
                else                  timer_d = timer_q - 16'd1;
            end
            ST_RD_REQ: state_d = ST_RD_CAP;
            ST_RD_CAP: state_d = ST_PUSH;
            ST_PUSH:   state_d = ST_IDLE;
            default:   state_d = ST_WR_MASK;
        endcase
    end

    // FSM outputs toward the PIO; idle whenever no access is owned
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = PIO_DATA;
        avm_writedata  = 32'h0;
        case (state_q)
            ST_WR_MASK: if (go_q) begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = PIO_MASK;
                avm_writedata  = 32'(mask_q);
            end
            ST_RD_REQ: begin
                avm_chipselect = 1'b1;
                avm_address    = PIO_DATA;
            end
            default: ;
        endcase
    end

    // EVENT and STATUS word assembly
    always_comb begin
        evt_word = '0;
        evt_word[WIDTH-1:0]                = sample_q;
        evt_word[EVT_DIFF_LSB +: WIDTH]    = diff;
        evt_word[EVT_VALID_BIT]            = 1'b1;
`ifdef SYSTEM_SET_SCANNER_TIMESTAMP_EN
        evt_word[EVT_TS_LSB +: 16]         = ts_cap_q;
`endif
        status_word = '0;
        status_word[7:0]           = 8'(fifo_count);
        status_word[STAT_OVF_BIT]  = overflow_q;
        status_word[STAT_BUSY_BIT] = (state_q != ST_IDLE);
    end

    // Datapath and slave register next values
    always_comb begin
        go_d         = 1'b1;
        mask_d       = mask_q;
        settle_d     = settle_q;
        sample_d     = (state_q == ST_RD_CAP) ? avm_readdata[WIDTH-1:0] : sample_q;
        last_d       = (state_q == ST_PUSH) ? sample_q : last_q;
        mask_dirty_d = mask_dirty_q & ~((state_q == ST_WR_MASK) && go_q);
        overflow_d   = overflow_q;
        irq_d        = ~fifo_empty;
        readdata_d   = readdata_q;
        if (cpu_wr && (address == REG_MASK)) begin
            mask_d       = writedata[WIDTH-1:0];
            mask_dirty_d = 1'b1;
        end
        if (cpu_wr && (address == REG_SETTLE)) settle_d = writedata[15:0];
        if (cpu_wr && (address == REG_STATUS) && writedata[STAT_OVF_BIT]) overflow_d = 1'b0;
        // A same-cycle pop frees the slot, so only a push with no pop overflows
        if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
        if (cpu_rd) begin
            case (address)
                REG_EVENT:  readdata_d = fifo_empty ? 32'h0 : 32'(fifo_rdata);
                REG_STATUS: readdata_d = status_word;
                REG_MASK:   readdata_d = 32'(mask_q);
                REG_SETTLE: readdata_d = 32'(settle_q);
                default:    readdata_d = 32'h0;
            endcase
        end
`ifdef SYSTEM_SET_SCANNER_TIMESTAMP_EN
        ts_d     = ts_q + 16'd1;
        ts_cap_d = (state_q == ST_RD_CAP) ? ts_q : ts_cap_q;
`endif
    end

    // Datapath and slave registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            go_q         <= 1'b0;
            mask_q       <= MASK_RESET;
            settle_q     <= SETTLE_RESET;
            sample_q     <= '0;
            last_q       <= '0;
            mask_dirty_q <= 1'b0;
            overflow_q   <= 1'b0;
            irq_q        <= 1'b0;
            readdata_q   <= '0;
`ifdef SYSTEM_SET_SCANNER_TIMESTAMP_EN
            ts_q         <= '0;
            ts_cap_q     <= '0;
`endif
        end else begin
            go_q         <= go_d;
            mask_q       <= mask_d;
            settle_q     <= settle_d;
            sample_q     <= sample_d;
            last_q       <= last_d;
            mask_dirty_q <= mask_dirty_d;
            overflow_q   <= overflow_d;
            irq_q        <= irq_d;
            readdata_q   <= readdata_d;
`ifdef SYSTEM_SET_SCANNER_TIMESTAMP_EN
            ts_q         <= ts_d;
            ts_cap_q     <= ts_cap_d;
`endif
        end
    end

endmodule

// File: tb/tb_system_set_scanner.sv
// tb/tb_system_set_scanner.sv - self-checking bench for system_set_scanner
module tb_system_set_scanner;

    logic        clk, reset_n;
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'h0;
    logic        pio_irq;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata, readdata;
    logic        irq;
    logic [4:0]  pio_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rd_cnt  = 0;
    int          wr_cnt  = 0;
    logic [31:0] last_wr_data = 32'h0;
    logic [1:0]  last_wr_addr = 2'd0;
    logic [31:0] exp_q[$];

`ifdef SYSTEM_SET_SCANNER_TIMESTAMP_EN
    localparam logic [31:0] EVT_CMP = 32'h0000_FFFF;
`else
    localparam logic [31:0] EVT_CMP = 32'hFFFF_FFFF;
`endif

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    system_set_scanner dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .pio_irq        (pio_irq),
        .address        (address),
        .chipselect     (chipselect),
        .read_n         (read_n),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .irq            (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PIO model: read data registered one cycle after the request
    always @(posedge clk)
        avm_readdata <= (avm_chipselect && avm_write_n && avm_address == 2'd0) ? {27'h0, pio_data} : 32'h0;

    // Bus monitor
    always @(negedge clk) begin
        if (reset_n && avm_chipselect) begin
            if (avm_write_n) rd_cnt = rd_cnt + 1;
            else begin
                wr_cnt       = wr_cnt + 1;
                last_wr_data = avm_writedata;
                last_wr_addr = avm_address;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic cpu_access(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                              output logic [31:0] rd);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = ~wr; read_n = wr; writedata = wd;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; writedata = 32'h0;
        rd = readdata;
    endtask

    task automatic pop_event(input string name);
        logic [31:0] rd, exp;
        cpu_access(2'd0, 1'b0, 32'h0, rd);
        exp = 32'h0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check(name, rd & EVT_CMP, exp);
    endtask

    task automatic status_low(input string name, input logic [31:0] exp);
        logic [31:0] rd;
        cpu_access(2'd1, 1'b0, 32'h0, rd);
        check(name, rd & 32'h1FF, exp);
    endtask

    task automatic scan_latency(output int n);
        bit found;
        found = 0; n = 0;
        @(negedge clk);
        pio_irq = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            n = n + 1;
            @(negedge clk);
            pio_irq = 1'b0;
            if (avm_chipselect && avm_write_n) found = 1;
        end
        if (!found) n = -1;
    endtask

    task automatic wait_rd_req(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (avm_chipselect && avm_write_n) found = 1;
        end
        if (!found) check(name, 32'h0, 32'h1);
    endtask

    task automatic toggle(input logic [4:0] v);
        @(negedge clk);
        pio_data = v; pio_irq = 1'b1;
        repeat (20) @(negedge clk);
        pio_irq = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int n, r0;
        reset_n = 1'b0; pio_irq = 1'b0; pio_data = 5'h0;
        address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; writedata = 32'h0;

        vecs[0]  = '{2'd3, 1'b0, 32'h0,         1'b1, 32'd50000};
        vecs[1]  = '{2'd2, 1'b0, 32'h0,         1'b1, 32'h1F};
        vecs[2]  = '{2'd1, 1'b0, 32'h0,         1'b1, 32'h0};
        vecs[3]  = '{2'd0, 1'b0, 32'h0,         1'b1, 32'h0};
        vecs[4]  = '{2'd3, 1'b1, 32'hABCD_1234, 1'b0, 32'h0};
        vecs[5]  = '{2'd3, 1'b0, 32'h0,         1'b1, 32'h1234};
        vecs[6]  = '{2'd2, 1'b1, 32'hFFFF_FFE5, 1'b0, 32'h0};
        vecs[7]  = '{2'd2, 1'b0, 32'h0,         1'b1, 32'h05};
        vecs[8]  = '{2'd2, 1'b1, 32'h1F,        1'b0, 32'h0};
        vecs[9]  = '{2'd3, 1'b1, 32'h4,         1'b0, 32'h0};
        vecs[10] = '{2'd3, 1'b0, 32'h0,         1'b1, 32'h4};
        vecs[11] = '{2'd2, 1'b0, 32'h0,         1'b1, 32'h1F};
        vecs[12] = '{2'd1, 1'b0, 32'h0,         1'b1, 32'h0};

        // Reset state and first mask write
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_avm_cs", {31'h0, avm_chipselect}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("wrmask_strobe", {29'h0, avm_chipselect, avm_write_n, avm_address == 2'd2}, 32'h5);
        check("wrmask_data", avm_writedata, 32'h1F);
        @(negedge clk);
        check("wrmask_one_cycle", {31'h0, avm_chipselect}, 32'h0);

        // Register table
        for (int i = 0; i < 13; i++) begin
            cpu_access(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd);
            if (vecs[i].chk) check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
        end
        repeat (3) @(posedge clk);
        check("mask_wr_data", last_wr_data, 32'h1F);
        check("mask_wr_addr", {30'h0, last_wr_addr}, 32'h2);

        // Press with SETTLE=4
        pio_data = 5'h01;
        exp_q.push_back(32'h0000_8101);
        scan_latency(n);
        check("settle4_latency", n, 5);
        repeat (3) @(negedge clk);
        check("irq_before_push", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_after_push", {31'h0, irq}, 32'h1);
        pop_event("press_event");
        check("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("irq_fall", {31'h0, irq}, 32'h0);

        // Held button re-polls without events, then release
        r0 = rd_cnt;
        repeat (32) @(negedge clk);
        check("held_polls", {31'h0, (rd_cnt - r0) >= 3 && (rd_cnt - r0) <= 5}, 32'h1);
        status_low("held_no_events", 32'h0);
        pio_data = 5'h00;
        exp_q.push_back(32'h0000_8100);
        repeat (20) @(negedge clk);
        pop_event("release_event");

        // SETTLE=0 behaves as 1
        cpu_access(2'd3, 1'b1, 32'h0, rd);
        repeat (4) @(negedge clk);
        scan_latency(n);
        check("settle0_latency", n, 2);
        repeat (10) @(negedge clk);
        status_low("settle0_no_event", 32'h0);
        cpu_access(2'd3, 1'b1, 32'h4, rd);

        // Mask excludes button 0
        cpu_access(2'd2, 1'b1, 32'h2, rd);
        repeat (4) @(negedge clk);
        check("mask2_wr_data", last_wr_data, 32'h2);
        toggle(5'h01);
        toggle(5'h00);
        status_low("mask2_no_events", 32'h0);
        cpu_access(2'd2, 1'b1, 32'h1F, rd);
        repeat (4) @(negedge clk);

        // Nine toggles overflow an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back((i % 2 == 0) ? 32'h0000_8101 : 32'h0000_8100);
            toggle((i % 2 == 0) ? 5'h01 : 5'h00);
        end
        status_low("full_overflow", 32'h108);
        check("irq_full", {31'h0, irq}, 32'h1);
        cpu_access(2'd1, 1'b1, 32'h100, rd);
        status_low("overflow_clear", 32'h008);

        // Pop lands in the PUSH cycle while full
        @(negedge clk);
        pio_data = 5'h00;
        wait_rd_req("pop_push_rdreq");
        @(negedge clk);
        pop_event("pop_push_pop");
        exp_q.push_back(32'h0000_8100);
        status_low("pop_push_status", 32'h008);
        for (int i = 0; i < 8; i++) pop_event($sformatf("drain%0d", i));
        pop_event("empty_read");
        status_low("drained_status", 32'h0);
        @(negedge clk);
        check("irq_drained", {31'h0, irq}, 32'h0);

        // Reset during SETTLE
        @(negedge clk);
        pio_data = 5'h01; pio_irq = 1'b1;
        for (int i = 0; i < 60 && !irq; i++) @(negedge clk);
        pio_irq = 1'b0;
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        cpu_access(2'd1, 1'b0, 32'h0, rd);
        check("pre_reset_count", rd & 32'hFF, 32'h1);
        wait_rd_req("pre_reset_rdreq");
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midscan_readdata", readdata, 32'h0);
        check("midscan_irq", {31'h0, irq}, 32'h0);
        check("midscan_avm_cs", {31'h0, avm_chipselect}, 32'h0);
        pio_data = 5'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rewrmask_strobe", {29'h0, avm_chipselect, avm_write_n, avm_address == 2'd2}, 32'h5);
        check("rewrmask_data", avm_writedata, 32'h1F);
        status_low("post_reset_status", 32'h0);
        cpu_access(2'd2, 1'b0, 32'h0, rd);
        check("post_reset_mask", rd, 32'h1F);
        cpu_access(2'd3, 1'b0, 32'h0, rd);
        check("post_reset_settle", rd, 32'd50000);
        exp_q.delete();
        pop_event("post_reset_event");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
